// File: rtl/display_arbiter_if.sv
// Handshake and data bundle between the four display requesters and the arbiter.
// The arbiter connects through the slave modport, the requester side through master.
interface display_arbiter_if;
    logic [3:0]  REQ;
    logic [15:0] DATA0;
    logic [15:0] DATA1;
    logic [15:0] DATA2;
    logic [15:0] DATA3;
    logic        LOCK;
    logic [3:0]  ACK;
    logic [15:0] DOUT;
    logic [1:0]  SRC;
    logic        BUSY;
    logic        SCAN_TICK;

    modport master (
        output REQ, DATA0, DATA1, DATA2, DATA3, LOCK,
        input  ACK, DOUT, SRC, BUSY, SCAN_TICK
    );

    modport slave (
        input  REQ, DATA0, DATA1, DATA2, DATA3, LOCK,
        output ACK, DOUT, SRC, BUSY, SCAN_TICK
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing the 4-digit seven-segment display among four requesters,
// with a minimum hold time per granted value and a free-running digit-scan tick.
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned SCAN_DIV    = 50_000
) (
    input  logic              CLK,
    input  logic              RST,
    display_arbiter_if.slave  bus
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic            tick_q, tick_d;
    logic [3:0]      ack_q, ack_d;
    logic [15:0]     dout_q, dout_d;
    logic [1:0]      src_q, src_d;
    logic [1:0]      last_q, last_d;

    logic            win_valid;
    logic [1:0]      win;
    logic [1:0]      cand;
    logic [15:0]     win_data;
    logic            grant_ok;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win_valid = 1'b0;
        win       = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_valid && bus.REQ[cand]) begin
                win_valid = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        case (win)
            2'd0:    win_data = bus.DATA0;
            2'd1:    win_data = bus.DATA1;
            2'd2:    win_data = bus.DATA2;
            default: win_data = bus.DATA3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        dout_d  = dout_q;
        src_d   = src_q;
        last_d  = last_q;

        grant_ok = 1'b0;
        if (!bus.LOCK) begin
            case (state_q)
                IDLE:    grant_ok = 1'b1;
                SHOW:    grant_ok = (cnt_q == HOLD_LAST);
                default: grant_ok = 1'b0;
            endcase
        end

        if (grant_ok && win_valid) begin
            state_d    = SHOW;
            cnt_d      = '0;
            ack_d      = '0;
            ack_d[win] = 1'b1;
            dout_d     = win_data;
            src_d      = win;
            last_d     = win;
        end else if (state_q == SHOW && !bus.LOCK && cnt_q != HOLD_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Tick is registered, so it appears the cycle after the counter sits at its top value.
    always_comb begin
        tick_d = (scan_q == SCAN_LAST);
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
        end else begin
            scan_d = scan_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
            dout_q  <= '0;
            src_q   <= '0;
            last_q  <= 2'd3;
            scan_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            src_q   <= src_d;
            last_q  <= last_d;
            scan_q  <= scan_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.ACK       = ack_q;
    assign bus.DOUT      = dout_q;
    assign bus.SRC       = src_q;
    assign bus.BUSY      = (state_q == SHOW) && (cnt_q != HOLD_LAST);
    assign bus.SCAN_TICK = tick_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES=8 and SCAN_DIV=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_display_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    display_arbiter_if bus ();

    display_arbiter #(
        .HOLD_CYCLES (8),
        .SCAN_DIV    (4)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.REQ  = '0;
        bus.LOCK = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.REQ   = '0;
        bus.LOCK  = 1'b0;
        bus.DATA0 = 16'h0000;
        bus.DATA1 = 16'h0000;
        bus.DATA2 = 16'h0000;
        bus.DATA3 = 16'h0000;
        @(negedge clk);
        n_checks++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", bus.ACK); end
        n_checks++; if (bus.DOUT !== 16'h0000) begin n_fail++; $display("FAIL rst_dout: got %h want 0000", bus.DOUT); end
        n_checks++; if (bus.SRC !== 2'd0) begin n_fail++; $display("FAIL rst_src: got %0d want 0", bus.SRC); end
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
        n_checks++; if (bus.SCAN_TICK !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %b want 0", bus.SCAN_TICK); end
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_checks++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL idle_ack edge %0d: got %b want 0000", c, bus.ACK); end
            n_checks++; if (bus.DOUT !== 16'h0000 || bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_out edge %0d: got dout=%h busy=%b want 0000/0", c, bus.DOUT, bus.BUSY); end
            n_checks++; if (bus.SCAN_TICK !== ((c % 4) == 0)) begin n_fail++; $display("FAIL scan_tick edge %0d: got %b want %b", c, bus.SCAN_TICK, ((c % 4) == 0)); end
        end
    endtask

    task automatic test_single();
        bus.DATA0 = 16'h1234;
        bus.REQ   = 4'b0001;
        @(negedge clk);
        n_checks++; if (bus.ACK !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b want 0001", bus.ACK); end
        n_checks++; if (bus.DOUT !== 16'h1234 || bus.SRC !== 2'd0) begin n_fail++; $display("FAIL single_data: got %h/%0d want 1234/0", bus.DOUT, bus.SRC); end
        n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy0: got %b want 1", bus.BUSY); end
        bus.REQ = '0;
        for (int j = 1; j <= 8; j++) begin
            if (j == 3) bus.DATA0 = 16'hFFFF;
            @(negedge clk);
            n_checks++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL single_ack_clr cyc %0d: got %b want 0000", j, bus.ACK); end
            n_checks++; if (bus.BUSY !== (j < 7)) begin n_fail++; $display("FAIL single_busy cyc %0d: got %b want %b", j, bus.BUSY, (j < 7)); end
            n_checks++; if (bus.DOUT !== 16'h1234) begin n_fail++; $display("FAIL single_hold_dout cyc %0d: got %h want 1234", j, bus.DOUT); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_src;
        logic [3:0]  exp_ack;
        logic [15:0] exp_dout;
        int          n;
        do_reset();
        bus.DATA0 = 16'hA000;
        bus.DATA1 = 16'hB111;
        bus.DATA2 = 16'hC222;
        bus.DATA3 = 16'hD333;
        bus.REQ   = 4'b1111;
        exp_src   = 2'd0;
        for (int g = 0; g < 5; g++) begin
            n = (g == 0) ? 1 : 8;
            for (int e = 1; e <= n; e++) begin
                @(negedge clk);
                if (e == n) begin
                    exp_ack = 4'b0001 << exp_src;
                    case (exp_src)
                        2'd0:    exp_dout = 16'hA000;
                        2'd1:    exp_dout = 16'hB111;
                        2'd2:    exp_dout = 16'hC222;
                        default: exp_dout = 16'hD333;
                    endcase
                    n_checks++; if (bus.ACK !== exp_ack) begin n_fail++; $display("FAIL rr_ack grant %0d: got %b want %b", g, bus.ACK, exp_ack); end
                    n_checks++; if (bus.SRC !== exp_src || bus.DOUT !== exp_dout) begin n_fail++; $display("FAIL rr_src grant %0d: got %0d/%h want %0d/%h", g, bus.SRC, bus.DOUT, exp_src, exp_dout); end
                    n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL rr_busy grant %0d: got %b want 1", g, bus.BUSY); end
                    exp_src = exp_src + 2'd1;
                end else begin
                    n_checks++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL rr_gap grant %0d cyc %0d: got %b want 0000", g, e, bus.ACK); end
                end
            end
        end
        bus.REQ = '0;
    endtask

    task automatic test_lock();
        do_reset();
        bus.DATA0 = 16'h1357;
        bus.DATA2 = 16'h2468;
        bus.REQ   = 4'b0001;
        @(negedge clk);
        n_checks++; if (bus.ACK !== 4'b0001) begin n_fail++; $display("FAIL lock_pre_ack: got %b want 0001", bus.ACK); end
        bus.REQ = '0;
        repeat (3) @(negedge clk);
        bus.LOCK = 1'b1;
        bus.REQ  = 4'b0100;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            n_checks++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL lock_ack cyc %0d: got %b want 0000", j, bus.ACK); end
            n_checks++; if (bus.DOUT !== 16'h1357 || bus.SRC !== 2'd0 || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL lock_frozen cyc %0d: got %h/%0d/%b want 1357/0/1", j, bus.DOUT, bus.SRC, bus.BUSY); end
        end
        bus.LOCK = 1'b0;
        // Frozen count is 3: four edges bring it to 7, the fifth edge grants.
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            if (e < 5) begin
                n_checks++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL unlock_early edge %0d: got %b want 0000", e, bus.ACK); end
            end else begin
                n_checks++; if (bus.ACK !== 4'b0100) begin n_fail++; $display("FAIL unlock_ack: got %b want 0100", bus.ACK); end
                n_checks++; if (bus.SRC !== 2'd2 || bus.DOUT !== 16'h2468) begin n_fail++; $display("FAIL unlock_data: got %0d/%h want 2/2468", bus.SRC, bus.DOUT); end
            end
        end
        bus.REQ = '0;
    endtask

    task automatic test_stale();
        for (int j = 1; j <= 30; j++) begin
            if (j == 15) bus.DATA2 = 16'h0F0F;
            @(negedge clk);
            n_checks++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL stale_ack cyc %0d: got %b want 0000", j, bus.ACK); end
            n_checks++; if (bus.DOUT !== 16'h2468) begin n_fail++; $display("FAIL stale_dout cyc %0d: got %h want 2468", j, bus.DOUT); end
            n_checks++; if (bus.BUSY !== (j < 7)) begin n_fail++; $display("FAIL stale_busy cyc %0d: got %b want %b", j, bus.BUSY, (j < 7)); end
        end
        bus.DATA2 = 16'h5A5A;
        bus.REQ   = 4'b0100;
        @(negedge clk);
        n_checks++; if (bus.ACK !== 4'b0100) begin n_fail++; $display("FAIL regrant_ack: got %b want 0100", bus.ACK); end
        n_checks++; if (bus.SRC !== 2'd2 || bus.DOUT !== 16'h5A5A || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL regrant_data: got %0d/%h/%b want 2/5a5a/1", bus.SRC, bus.DOUT, bus.BUSY); end
        bus.REQ = '0;
    endtask

    task automatic test_async_reset();
        repeat (8) @(negedge clk);
        bus.DATA1 = 16'hBEEF;
        bus.REQ   = 4'b0010;
        @(negedge clk);
        n_checks++; if (bus.ACK !== 4'b0010 || bus.DOUT !== 16'hBEEF) begin n_fail++; $display("FAIL ares_pre: got %b/%h want 0010/beef", bus.ACK, bus.DOUT); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL ares_ack: got %b want 0000", bus.ACK); end
        n_checks++; if (bus.DOUT !== 16'h0000 || bus.BUSY !== 1'b0 || bus.SRC !== 2'd0) begin n_fail++; $display("FAIL ares_out: got %h/%b/%0d want 0000/0/0", bus.DOUT, bus.BUSY, bus.SRC); end
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        bus.DATA3 = 16'hC0DE;
        bus.REQ   = 4'b1000;
        @(negedge clk);
        n_checks++; if (bus.ACK !== 4'b1000) begin n_fail++; $display("FAIL post_rst_ack: got %b want 1000", bus.ACK); end
        n_checks++; if (bus.SRC !== 2'd3 || bus.DOUT !== 16'hC0DE || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL post_rst_data: got %0d/%h/%b want 3/c0de/1", bus.SRC, bus.DOUT, bus.BUSY); end
        bus.REQ = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_stale();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
